// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer with a built-in ERROR default slave.
// Optional unmapped-transfer counter on err_count is enabled by defining DEC_ERR_CNT_EN.
//
// state | meaning
// IDLE  | default slave idle, zero-wait OKAY
// ERR1  | first ERROR cycle, HREADY low
// ERR2  | second ERROR cycle, HREADY high
module ahb_decode_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  parameter int SEL_LSB    = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [15:0]                  err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [SEL_BITS-1:0] r_d_idx;
  logic                r_d_map;
  logic                r_d_act;
  logic [SEL_BITS-1:0] w_idx;
  logic                w_mapped;
  logic                w_unmapped_xfer;
  logic [DATA_W-1:0]   w_s_rdata;
  logic                w_s_ready;
  logic                w_s_resp;
  logic                w_def_ready;
  logic                w_def_resp;
  logic                w_unused;

  assign w_idx    = HADDR[SEL_LSB +: SEL_BITS];
  assign w_mapped = (int'(w_idx) < NUM_SLAVES);
  assign w_unused = ^{HADDR, HTRANS[0]};

  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      HSEL[i] = w_mapped && (w_idx == SEL_BITS'(i));
  end

  always_comb begin
    w_s_rdata = '0;
    w_s_ready = 1'b1;
    w_s_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_d_idx == SEL_BITS'(i)) begin
        w_s_rdata = HRDATA_S[i*DATA_W +: DATA_W];
        w_s_ready = HREADYOUT_S[i];
        w_s_resp  = HRESP_S[i];
      end
    end
  end

  // ERR states are only ever entered with an active transfer captured in the data phase
  assign w_def_ready = !(r_d_act && (r_state == S_ERR1));
  assign w_def_resp  = r_d_act && (r_state != S_IDLE);

  assign HRDATA = r_d_map ? w_s_rdata : '0;
  assign HREADY = r_d_map ? w_s_ready : w_def_ready;
  assign HRESP  = r_d_map ? w_s_resp  : w_def_resp;

  assign w_unmapped_xfer = HREADY && HTRANS[1] && !w_mapped;

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_unmapped_xfer ? S_ERR1 : S_IDLE;
      S_ERR1:  w_state_nxt = S_ERR2;
      S_ERR2:  w_state_nxt = (HTRANS[1] && !w_mapped) ? S_ERR1 : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data-phase routing only advances when the bus is ready, so wait states keep the owner
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_d_idx <= '0;
      r_d_map <= 1'b0;
      r_d_act <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (HREADY) begin
        r_d_idx <= w_idx;
        r_d_map <= w_mapped;
        r_d_act <= HTRANS[1];
      end
    end
  end

`ifdef DEC_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge HCLK) begin
    if (HRESET)
      r_err_count <= 16'h0000;
    else if (w_unmapped_xfer && (r_err_count != 16'hFFFF))
      r_err_count <= r_err_count + 16'd1;
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Randomized scoreboard bench for ahb_decode_mux with three slaves in a four-entry index space.
// Expected responses are queued per accepted transfer and checked by an independent monitor.
module tb_ahb_decode_mux;
  localparam int NS = 3;
  localparam int DW = 32;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic [31:0]      HADDR = '0;
  logic [1:0]       HTRANS = '0;
  logic [NS-1:0]    HSEL;
  logic [NS*DW-1:0] HRDATA_S = '0;
  logic [NS-1:0]    HREADYOUT_S = '1;
  logic [NS-1:0]    HRESP_S = '0;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic [15:0]      err_count;

  ahb_decode_mux #(
    .NUM_SLAVES(NS), .SEL_BITS(2), .SEL_LSB(16), .ADDR_W(32), .DATA_W(DW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .err_count(err_count)
  );

  always #5 HCLK = ~HCLK;

  // One entry per data phase: wait cycles, final data/resp, resp during waits, error count
  typedef struct {
    int          waits;
    logic [31:0] data;
    logic        resp;
    logic        wresp;
    int          errc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          seen_w = 0;
  int          cur_slave = -1;
  int          cur_left = 0;
  logic [31:0] cur_data = '0;
  logic        cur_resp = 1'b0;
  logic [31:0] nxt_addr;
  logic [1:0]  nxt_trans;
  int          err_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_err();
`ifdef DEC_ERR_CNT_EN
    return (err_model > 65535) ? 65535 : err_model;
`else
    return 0;
`endif
  endfunction

  task automatic flush_to_reset();
    exp_t e;
    q.delete();
    seen_w    = 0;
    err_model = 0;
    cur_slave = -1;
    cur_left  = 0;
    e.waits = 0; e.data = '0; e.resp = 1'b0; e.wresp = 1'b0; e.errc = 0;
    q.push_back(e);
  endtask

  // The presented address phase completes: it becomes the data phase and its response is queued
  task automatic accept();
    exp_t e;
    int   idx;
    bit   act;
    idx = int'(nxt_addr[17:16]);
    act = nxt_trans[1];
    if (idx < NS) begin
      cur_slave = idx;
      e.waits = act ? int'($urandom_range(0, 3)) : 0;
      e.data  = $urandom;
      e.resp  = act ? ($urandom_range(0, 3) == 0) : 1'b0;
      e.wresp = 1'b0;
    end else begin
      cur_slave = -1;
      e.waits = act ? 1 : 0;
      e.data  = '0;
      e.resp  = act;
      e.wresp = act;
      if (act) err_model++;
    end
    e.errc   = exp_err();
    cur_left = e.waits;
    cur_data = e.data;
    cur_resp = e.resp;
    q.push_back(e);
    nxt_addr  = $urandom;
    nxt_trans = 2'($urandom_range(0, 3));
  endtask

  task automatic cycle();
    logic [NS-1:0] exp_sel;
    int            idx;
    for (int i = 0; i < NS; i++) begin
      if (i == cur_slave && cur_left == 0) begin
        HREADYOUT_S[i]        = 1'b1;
        HRESP_S[i]            = cur_resp;
        HRDATA_S[i*DW +: DW]  = cur_data;
      end else if (i == cur_slave) begin
        HREADYOUT_S[i]        = 1'b0;
        HRESP_S[i]            = 1'b0;
        HRDATA_S[i*DW +: DW]  = $urandom;
      end else begin
        HREADYOUT_S[i]        = 1'($urandom);
        HRESP_S[i]            = 1'($urandom);
        HRDATA_S[i*DW +: DW]  = $urandom;
      end
    end
    HADDR  = nxt_addr;
    HTRANS = nxt_trans;
    #1;
    idx     = int'(nxt_addr[17:16]);
    exp_sel = '0;
    if (idx < NS) exp_sel[idx] = 1'b1;
    check("hsel", 32'(HSEL), 32'(exp_sel));
    @(posedge HCLK);
    if (cur_left == 0) accept();
    else cur_left--;
    #1;
  endtask

  always @(negedge HCLK) begin
    if (!HRESET && q.size() > 0) begin
      check("err_count", 32'(err_count), 32'(q[0].errc));
      if (!HREADY) begin
        seen_w++;
        check("wait_hresp", 32'(HRESP), 32'(q[0].wresp));
      end else begin
        m_e = q.pop_front();
        check("hrdata", HRDATA, m_e.data);
        check("hresp", 32'(HRESP), 32'(m_e.resp));
        check("wait_cycles", seen_w, m_e.waits);
        seen_w = 0;
      end
    end
  end

  initial begin
    nxt_addr  = 32'h0002_0010;
    nxt_trans = 2'b10;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    flush_to_reset();

    repeat (600) cycle();

    // Abandon an error response in its first cycle via reset
    nxt_addr  = 32'h0003_0000;
    nxt_trans = 2'b10;
    for (int k = 0; k < 10; k++) begin
      if (cur_slave == -1 && cur_left == 1) break;
      cycle();
    end
    HRESET = 1'b1;
    HTRANS = 2'b00;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    flush_to_reset();

    repeat (200) cycle();

    check("queue_depth", q.size(), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_decode_mux.md
Name: ahb_decode_mux

Overview:
- Parametrised AHB-Lite address decoder plus slave-to-master response multiplexer for one master and NUM_SLAVES slaves.
- Address-phase HSEL generation is combinational.
- The data-phase slave index is registered only when HREADY is high.
- A built-in default slave returns the two-cycle AHB ERROR response for unmapped transfers.
- Sits between the master and the slave bank, replacing the fixed 4-slave decoder.

Parameters:
- NUM_SLAVES, 4: number of mapped slaves; 1 to 2**SEL_BITS.
- SEL_BITS, 2: width of the HADDR slave-index field.
- SEL_LSB, 16: bit position of the index field LSB in HADDR.
- ADDR_W, 32: HADDR width; SEL_LSB+SEL_BITS <= ADDR_W.
- DATA_W, 32: read data width.

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  ADDR_W  master address (address phase).
- HTRANS  in  2  master transfer type; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSEL  out  NUM_SLAVES  one-hot slave select, address phase.
- HRDATA_S  in  NUM_SLAVES*DATA_W  slave read data; slave i at bits [i*DATA_W +: DATA_W].
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs.
- HRESP_S  in  NUM_SLAVES  slave responses; 0 OKAY, 1 ERROR.
- HRDATA  out  DATA_W  muxed read data to master.
- HREADY  out  1  muxed ready, to master and all slaves.
- HRESP  out  1  muxed response to master.
- err_count  out  16  unmapped-transfer counter (see Optional Feature).

Behaviour:
- Decode: idx = HADDR[SEL_LSB +: SEL_BITS].
  - mapped = (idx < NUM_SLAVES).
  - HSEL[i] = mapped && (idx == i), combinational, independent of HTRANS.
  - Unmapped address: HSEL all zero.
- Data-phase register: on HCLK rise with HREADY=1, capture d_idx <= idx, d_map <= mapped, d_act <= HTRANS[1].
  - With HREADY=0 these hold; this fixes the wait-state misrouting of the previous decoder.
- Output mux, data phase mapped (d_map=1): HRDATA = HRDATA_S[d_idx], HREADY = HREADYOUT_S[d_idx], HRESP = HRESP_S[d_idx].
- Output mux, data phase default slave (d_map=0): HRDATA = 0; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=0. Go to ERR1 when HREADY=1 and HTRANS[1]=1 and mapped=0, else stay.
  - ERR1: HREADY=0, HRESP=1. Unconditionally go to ERR2.
  - ERR2: HREADY=1, HRESP=1. Go to ERR1 if HTRANS[1]=1 and mapped=0 (back-to-back unmapped); else go to IDLE.
- Unmapped IDLE or BUSY: zero-wait OKAY; no FSM activity.
- A mapped slave sees HREADY=0 during ERR1. Its address phase is extended and it must not sample.
- Reset values (after the reset edge): FSM=IDLE, d_map=0, d_act=0, d_idx=0, HREADY=1, HRESP=0, HRDATA=0, err_count=0.
  - HSEL stays combinational from HADDR.
- Reset mid-operation (e.g. in ERR1, or during a slave wait state): HRESET=1 at a clock edge forces all reset values on the next cycle. The pending transfer is abandoned.
- NUM_SLAVES = 2**SEL_BITS: the default slave is unreachable. FSM logic may be optimised away but ports remain.
- Latency: decode 0 cycles; response mux 0 cycles after d_idx registers.

Optional Feature:
- Macro: DEC_ERR_CNT_EN.
- Defined: err_count increments by 1 on each clock edge where HREADY=1, HTRANS[1]=1, mapped=0 and HRESET=0.
  - Saturates at 16'hFFFF; cleared only by HRESET.
- Undefined: err_count tied to 16'h0000, no counter flops. The port is always present so instantiations do not change.

Test Plan:
- Reset: hold HRESET=1 two cycles, release -> HREADY=1, HRESP=0, HRDATA=0, err_count=0.
- Mapped read: NUM_SLAVES=3, HADDR=0x0002_0010, HTRANS=NONSEQ -> HSEL=3'b100; next cycle HRDATA = slave2 data (0xA5A5_0002), HRESP=0.
- Slave wait state: slave1 drives HREADYOUT_S[1]=0 for 3 cycles while the master presents the next address to slave0 -> HREADY=0 for 3 cycles; HRDATA/HRESP keep tracking slave1 until HREADYOUT_S[1]=1; then d_idx=0.
- Unmapped access: NUM_SLAVES=3, HADDR=0x0003_0000, NONSEQ -> HSEL=000, then HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then IDLE. With DEC_ERR_CNT_EN, err_count=1.
- Back-to-back unmapped: two NONSEQ to 0x0003_xxxx with the second presented during ERR2 -> FSM ERR1,ERR2,ERR1,ERR2,IDLE; err_count=2. Unmapped IDLE transfer -> OKAY zero-wait, err_count unchanged.
- Reset mid-error: assert HRESET during ERR1 -> next cycle HREADY=1, HRESP=0, FSM IDLE; err_count=0.
